// File: rtl/bcd_seq_adder_pkg.sv
// Shared definitions for the digit-serial BCD adder: digit width, largest legal digit, FSM states.
package bcd_pkg;
    localparam int         DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/bcd_seq_adder_if.sv
// Request/result handshake bundle between the arithmetic front end and the BCD sequential adder.
interface bcd_seq_adder_if #(parameter int NDIG = 4);
    logic                in_valid;
    logic                in_ready;
    logic [4*NDIG-1:0]   a;
    logic [4*NDIG-1:0]   b;
    logic                cin;
    logic                op;
    logic                out_valid;
    logic                out_ready;
    logic [4*NDIG-1:0]   sum;
    logic                cout;
    logic                err;

    modport master (
        output in_valid, a, b, cin, op, out_ready,
        input  in_ready, out_valid, sum, cout, err
    );

    modport slave (
        input  in_valid, a, b, cin, op, out_ready,
        output in_ready, out_valid, sum, cout, err
    );
endinterface

// File: rtl/bcd_seq_adder_digit_add.sv
// Combinational one-digit BCD adder: binary add, then +6 correction when the raw sum leaves 0..9.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               ci,
    output logic [DIGIT_W-1:0] s,
    output logic               co
);
    logic [DIGIT_W:0] raw;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, ci};
        co  = raw[DIGIT_W] || (raw[DIGIT_W-1:0] > BCD_MAX);
        s   = raw[DIGIT_W-1:0] + (co ? DIGIT_W'(6) : DIGIT_W'(0));
    end
endmodule

// File: rtl/bcd_seq_adder.sv
// Digit-serial BCD add/subtract controller: one shared digit adder walks the operands LSD first.
module bcd_seq_adder
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    bcd_seq_adder_if.slave   bus
);
    localparam int W     = DIGIT_W * NDIG;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [W-1:0]       a_r, b_r, sum_r, sum_nxt;
    logic               op_r, err_r;
    logic [DIGIT_W-1:0] a_d, b_d, b_eff, s_d;
    logic               co_d, last, accept;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        has_bad_digit = 1'b0;
        for (int k = 0; k < NDIG; k++)
            if (v[k*DIGIT_W +: DIGIT_W] > BCD_MAX) has_bad_digit = 1'b1;
    endfunction

    assign accept = (state == IDLE) && bus.in_valid;
    assign last   = (idx == IDX_W'(NDIG - 1));

    always_comb begin
        a_d     = '0;
        b_d     = '0;
        sum_nxt = sum_r;
        for (int k = 0; k < NDIG; k++) begin
            if (idx == IDX_W'(k)) begin
                a_d = a_r[k*DIGIT_W +: DIGIT_W];
                b_d = b_r[k*DIGIT_W +: DIGIT_W];
                sum_nxt[k*DIGIT_W +: DIGIT_W] = s_d;
            end
        end
        // Nine's complement of b plus a seeded carry of 1 gives ten's-complement subtraction.
        b_eff = op_r ? (BCD_MAX - b_d) : b_d;
    end

    bcd_digit_add u_digit (
        .a  (a_d),
        .b  (b_eff),
        .ci (carry),
        .s  (s_d),
        .co (co_d)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = RUN;
            RUN:     if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            sum_r <= '0;
            err_r <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                idx   <= '0;
                carry <= bus.op ? 1'b1 : bus.cin;
                sum_r <= '0;
                err_r <= has_bad_digit(bus.a) | has_bad_digit(bus.b);
            end else if (state == RUN) begin
                sum_r <= sum_nxt;
                carry <= co_d;
                if (!last) idx <= idx + IDX_W'(1);
            end
        end
    end

    // Operand registers hold data only; they are always reloaded before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r  <= bus.a;
            b_r  <= bus.b;
            op_r <= bus.op;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_r;
    assign bus.cout      = carry;
    assign bus.err       = err_r;
endmodule

// File: tb/tb_bcd_seq_adder.sv
// Scoreboard bench for bcd_seq_adder (NDIG=4): decimal reference model, handshake and reset cases.
module tb_bcd_seq_adder;
    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
        bit           chk_val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    bcd_seq_adder_if #(.NDIG(NDIG)) bus ();

    bcd_seq_adder #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int from_bcd(input logic [W-1:0] v);
        int r = 0;
        for (int k = NDIG - 1; k >= 0; k--) r = r * 10 + int'(v[k*4 +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        for (int k = 0; k < NDIG; k++) begin
            r[k*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic bad(input logic [W-1:0] v);
        for (int k = 0; k < NDIG; k++) if (v[k*4 +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic op);
        exp_t e;
        int   r;
        e.err     = bad(a) | bad(b);
        e.chk_val = !e.err;
        if (!op) begin
            r      = from_bcd(a) + from_bcd(b) + int'(cin);
            e.cout = (r >= 10000);
            r      = r % 10000;
        end else begin
            r      = from_bcd(a) - from_bcd(b);
            e.cout = (r >= 0);
            if (r < 0) r += 10000;
        end
        e.sum = to_bcd(r);
        return e;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int k = 0; k < NDIG; k++) r[k*4 +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic op);
        int n = 0;
        bus.a = a; bus.b = b; bus.cin = cin; bus.op = op; bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_wait", 32'(n < 20), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        sb.push_back(model(a, b, cin, op));
    endtask

    task automatic collect();
        int   n = 0;
        exp_t e;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", n, 4);
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        chk("err", bus.err, e.err);
        if (e.chk_val) begin
            chk("sum", bus.sum, e.sum);
            chk("cout", bus.cout, e.cout);
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("out_valid_drop", bus.out_valid, 0);
        chk("in_ready_back", bus.in_ready, 1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic op);
        send(a, b, cin, op);
        collect();
        release_out();
    endtask

    initial begin
        logic [W-1:0] held_sum;
        logic         held_cout, held_err;

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.op = 1'b0;
        #2;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sum", bus.sum, 0);
        chk("rst_cout", bus.cout, 0);
        chk("rst_err", bus.err, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed add cases
        run_op(16'h1234, 16'h5678, 1'b0, 1'b0);
        run_op(16'h9999, 16'h0000, 1'b1, 1'b0);
        run_op(16'h0999, 16'h0001, 1'b0, 1'b0);
        // Subtract with and without borrow; cin must be ignored
        run_op(16'h0500, 16'h0123, 1'b1, 1'b1);
        run_op(16'h0123, 16'h0500, 1'b0, 1'b1);
        run_op(16'h4321, 16'h4321, 1'b0, 1'b1);
        // Invalid digit then a clean request
        run_op(16'h12A4, 16'h0001, 1'b0, 1'b0);
        run_op(16'h0042, 16'h0F00, 1'b0, 1'b1);
        run_op(16'h2222, 16'h3333, 1'b1, 1'b0);

        // Back-pressure in DONE with in_valid and changing operands
        send(16'h1357, 16'h2468, 1'b0, 1'b0);
        collect();
        held_sum = bus.sum; held_cout = bus.cout; held_err = bus.err;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.a = rand_bcd(); bus.b = rand_bcd(); bus.op = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("hold_sum", bus.sum, held_sum);
            chk("hold_cout", bus.cout, held_cout);
            chk("hold_err", bus.err, held_err);
            chk("hold_in_ready", bus.in_ready, 0);
            chk("hold_out_valid", bus.out_valid, 1);
        end
        bus.in_valid = 1'b0;
        release_out();
        run_op(16'h8765, 16'h1235, 1'b0, 1'b0);

        // Reset in RUN at idx=2
        send(16'h5555, 16'h4444, 1'b0, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_sum", bus.sum, 0);
        chk("abort_in_ready", bus.in_ready, 1);
        void'(sb.pop_front());
        @(posedge clk); #1;
        chk("abort_hold_in_ready", bus.in_ready, 1);
        chk("abort_hold_out_valid", bus.out_valid, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);
        run_op(16'h0789, 16'h0211, 1'b1, 1'b0);

        // Random valid operands
        for (int i = 0; i < 8; i++)
            run_op(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
